// File: rtl/cpu_check_pkg.sv
// Shared types and constants for the run-to-completion checker and the
// CPU benches that use it.
package cpu_check_pkg;

    // Checker phases, in the order a run walks through them.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } check_state_t;

    // CPU variants the checker is used with; the benches select on this.
    typedef enum logic [1:0] {
        SingleCyc = 2'd0,
        MultiCyc  = 2'd1,
        Pipeline  = 2'd2
    } cpu_type_t;

    // beq $0,$0,-1 : the self-loop every test program ends on.
    localparam logic [31:0] MIPS_HALT_BEQ = 32'h1000_FFFF;

    // Bits needed to hold 0 .. n-1, never less than one bit so that
    // degenerate parameter choices still give legal vector widths.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_checker_halt_detector.sv
// Halt detection: a core is considered halted once its PC has stopped
// moving for HALT_STABLE consecutive cycles, or immediately when it
// presents the halt instruction (if that match is enabled).
module halt_detector
    import cpu_check_pkg::*;
#(
    parameter int          HALT_STABLE   = 8,
    parameter bit          HALT_INSTR_EN = 1'b1,
    parameter logic [31:0] HALT_INSTR    = MIPS_HALT_BEQ
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_debug,
    input  logic [31:0] instr_debug,
    output logic        halt
);

    localparam int               SC_W    = width_of(HALT_STABLE);
    localparam logic [SC_W-1:0]  SC_TERM = SC_W'(HALT_STABLE - 1);

    logic [31:0]     prev_pc;
    logic [SC_W-1:0] stable_cnt;
    logic            pc_same;
    logic            instr_hit;

    assign pc_same   = (pc_debug == prev_pc);
    assign instr_hit = HALT_INSTR_EN && (instr_debug == HALT_INSTR);

    // Halt is combinational here so the checker sees it in the same cycle;
    // stable_cnt holds how many earlier consecutive cycles already matched.
    always_comb begin
        halt = (pc_same && (stable_cnt == SC_TERM)) || instr_hit;
    end

    // Track the previous PC and count unchanged cycles, saturating at the
    // terminal value so halt stays asserted while the PC stays parked.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc    <= '0;
            stable_cnt <= '0;
        end else begin
            prev_pc <= pc_debug;
            if (!pc_same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != SC_TERM) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_checker.sv
// Run-to-completion checker that sits on a CPU's debug ports: waits for the
// program to halt, lets the pipeline drain, then walks a table of expected
// register values one entry per cycle and reports the verdict.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | program executing; counting cycles, watching for halt
//   DRAIN | halted; letting in-flight writebacks land
//   CHECK | comparing one table entry per cycle against regs_debug
//   DONE  | verdict valid; held until reset
module cpu_run_checker
    import cpu_check_pkg::*;
#(
    parameter int          N_CHECKS      = 4,
    parameter int          MAX_CYCLES    = 1000,
    parameter int          HALT_STABLE   = 8,
    parameter bit          HALT_INSTR_EN = 1'b1,
    parameter logic [31:0] HALT_INSTR    = MIPS_HALT_BEQ,
    parameter int          DRAIN_CYCLES  = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [31:0]                                   pc_debug,
    input  logic [31:0]                                   instr_debug,
    input  logic [31:0]                                   regs_debug [0:31],
    input  logic [((N_CHECKS > 0) ? N_CHECKS : 1)-1:0]    exp_en,
    input  logic [((N_CHECKS > 0) ? N_CHECKS : 1)*5-1:0]  exp_idx,
    input  logic [((N_CHECKS > 0) ? N_CHECKS : 1)*32-1:0] exp_val,
    output logic                                          done,
    output logic                                          pass,
    output logic                                          timeout,
    output logic [width_of(N_CHECKS + 1)-1:0]             fail_count,
    output logic [width_of(N_CHECKS)-1:0]                 first_fail_idx,
    output logic [31:0]                                   first_fail_got,
    output logic [width_of(MAX_CYCLES + 1)-1:0]           cycle_count
);

    // An empty table still spends one cycle in CHECK, so size the walk
    // over at least one slot.
    localparam int N_ENT = (N_CHECKS > 0) ? N_CHECKS : 1;
    localparam int FC_W  = width_of(N_CHECKS + 1);
    localparam int IDX_W = width_of(N_CHECKS);
    localparam int CC_W  = width_of(MAX_CYCLES + 1);
    localparam int DR_W  = width_of(DRAIN_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ENT - 1);
    localparam logic [CC_W-1:0]  CC_LAST    = CC_W'(MAX_CYCLES - 1);
    localparam logic [DR_W-1:0]  DRAIN_LOAD = DR_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    // Leaving RUN skips DRAIN entirely when no drain time is configured.
    localparam check_state_t AFTER_RUN = (DRAIN_CYCLES > 0) ? DRAIN : CHECK;

    check_state_t     state;
    logic             halt;
    logic [DR_W-1:0]  drain_cnt;
    logic [IDX_W-1:0] check_idx;

    logic             sel_en;
    logic [4:0]       sel_reg;
    logic [31:0]      sel_val;
    logic [31:0]      sel_got;
    logic             mismatch;
    logic [FC_W-1:0]  fc_next;

    halt_detector #(
        .HALT_STABLE   (HALT_STABLE),
        .HALT_INSTR_EN (HALT_INSTR_EN),
        .HALT_INSTR    (HALT_INSTR)
    ) u_halt (
        .clk         (clk),
        .reset       (reset),
        .pc_debug    (pc_debug),
        .instr_debug (instr_debug),
        .halt        (halt)
    );

    // Select the table entry being visited and compare it against the
    // live register snapshot; only meaningful while in CHECK.
    always_comb begin
        sel_en   = exp_en[check_idx];
        sel_reg  = exp_idx[int'(check_idx) * 5 +: 5];
        sel_val  = exp_val[int'(check_idx) * 32 +: 32];
        sel_got  = regs_debug[sel_reg];
        mismatch = (N_CHECKS > 0) && (state == CHECK) && sel_en && (sel_got != sel_val);
        fc_next  = fail_count + FC_W'(mismatch);
    end

    // Phase sequencing plus every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            drain_cnt      <= '0;
            check_idx      <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            cycle_count    <= '0;
        end else begin
            case (state)
                RUN: begin
                    // Halt takes priority over the budget running out in
                    // the same cycle; either way the count freezes.
                    if (halt) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= AFTER_RUN;
                    end else if (cycle_count == CC_LAST) begin
                        timeout   <= 1'b1;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= AFTER_RUN;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fc_next;
                        if (fail_count == '0) begin
                            first_fail_idx <= check_idx;
                            first_fail_got <= sel_got;
                        end
                    end
                    // The verdict uses fc_next so the last entry's result
                    // is included in the same cycle done rises.
                    if (check_idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (fc_next == '0) && !timeout;
                    end else begin
                        check_idx <= check_idx + 1'b1;
                    end
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_checker.sv
// Directed bench for cpu_run_checker: a stub core drives pc/instr and a
// fixed register snapshot; expected verdicts are queued per scenario and a
// monitor compares them when done rises.
module tb_cpu_run_checker;
    import cpu_check_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_debug;
    logic [31:0] instr_debug;
    logic [31:0] regs [0:31];
    logic [3:0]  exp_en;
    logic [19:0] exp_idx;
    logic [127:0] exp_val;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [2:0]  fail_count;
    logic [1:0]  first_fail_idx;
    logic [31:0] first_fail_got;
    logic [5:0]  cycle_count;

    cpu_run_checker #(
        .N_CHECKS      (4),
        .MAX_CYCLES    (50),
        .HALT_STABLE   (4),
        .HALT_INSTR_EN (1'b1),
        .HALT_INSTR    (MIPS_HALT_BEQ),
        .DRAIN_CYCLES  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_debug       (pc_debug),
        .instr_debug    (instr_debug),
        .regs_debug     (regs),
        .exp_en         (exp_en),
        .exp_idx        (exp_idx),
        .exp_val        (exp_val),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_got (first_fail_got),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_cyc;
        logic        pass;
        logic        tmo;
        logic [2:0]  fc;
        logic [1:0]  ffi;
        logic [31:0] ffg;
        logic [5:0]  cc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hold_cyc = -1;
    int   instr_cyc = -1;
    int   done_seen = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Stub core: pc steps by 4 each cycle until hold_cyc, then parks.
    task automatic drive();
        pc_debug    = (hold_cyc < 0 || cyc < hold_cyc) ? 32'(4 * cyc) : 32'(4 * hold_cyc);
        instr_debug = (cyc == instr_cyc) ? MIPS_HALT_BEQ : 32'h0000_0020;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic set_entry(input int i, input logic [4:0] r, input logic [31:0] v);
        exp_idx[i*5 +: 5]  = r;
        exp_val[i*32 +: 32] = v;
    endtask

    // Standard program result and table: regs 8..11 = 8,7,F,1.
    task automatic set_std();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[8] = 32'h8; regs[9] = 32'h7; regs[10] = 32'hF; regs[11] = 32'h1;
        exp_en = 4'b1111;
        set_entry(0, 5'd8, 32'h8);
        set_entry(1, 5'd9, 32'h7);
        set_entry(2, 5'd10, 32'hF);
        set_entry(3, 5'd11, 32'h1);
    endtask

    task automatic push_exp(input int dc, input logic p, input logic t, input logic [2:0] fc,
                            input logic [1:0] ffi, input logic [31:0] ffg, input logic [5:0] cc);
        exp_t e;
        e.done_cyc = dc; e.pass = p; e.tmo = t; e.fc = fc; e.ffi = ffi; e.ffg = ffg; e.cc = cc;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_timeout"}, 32'(timeout), 32'h0);
        chk({tag, "_fail_count"}, 32'(fail_count), 32'h0);
        chk({tag, "_first_fail_idx"}, 32'(first_fail_idx), 32'h0);
        chk({tag, "_first_fail_got"}, first_fail_got, 32'h0);
        chk({tag, "_cycle_count"}, 32'(cycle_count), 32'h0);
    endtask

    // Hold reset two edges, check reset values, release into cycle 0.
    task automatic start_run(input int hold, input int icyc);
        hold_cyc  = hold;
        instr_cyc = icyc;
        reset = 1'b1;
        cyc = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        cyc = 0;
        drive();
    endtask

    task automatic wait_done();
        int seen0;
        seen0 = done_seen;
        while (done_seen == seen0 && cyc < 200) step();
        chk("done_observed", 32'(done_seen - seen0), 32'h1);
        if (done_seen == seen0 && exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (3) step();
    endtask

    // Monitor: on each rising done, pop the queued verdict and compare.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_prev = 1'b0;
            end else begin
                if (done_prev) chk("done_sticky", 32'(done), 32'h1);
                if (done && !done_prev) begin
                    done_seen++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: done rose at cycle %0d with nothing queued", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                        chk("pass", 32'(pass), 32'(e.pass));
                        chk("timeout", 32'(timeout), 32'(e.tmo));
                        chk("fail_count", 32'(fail_count), 32'(e.fc));
                        chk("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
                        chk("first_fail_got", first_fail_got, e.ffg);
                        chk("cycle_count", 32'(cycle_count), 32'(e.cc));
                    end
                end
                done_prev = done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        exp_en = '0; exp_idx = '0; exp_val = '0;
        set_std();
        drive();

        // Stable-PC halt at 14, everything matches.
        set_std();
        push_exp(21, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 6'd14);
        start_run(10, -1);
        wait_done();

        // One mismatch on entry 2.
        set_std(); regs[10] = 32'hE;
        push_exp(21, 1'b0, 1'b0, 3'd1, 2'd2, 32'hE, 6'd14);
        start_run(10, -1);
        wait_done();

        // Two mismatches: only the first is latched.
        set_std(); regs[9] = 32'h5; regs[10] = 32'hE;
        push_exp(21, 1'b0, 1'b0, 3'd2, 2'd1, 32'h5, 6'd14);
        start_run(10, -1);
        wait_done();

        // PC never stops: timeout at 49, checks still run.
        set_std();
        push_exp(56, 1'b0, 1'b1, 3'd0, 2'd0, 32'h0, 6'd49);
        start_run(-1, -1);
        wait_done();

        // Halt lands exactly on the last budget cycle: halt wins.
        set_std();
        push_exp(56, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 6'd49);
        start_run(45, -1);
        wait_done();

        // Halt instruction at cycle 7 while pc is still moving.
        set_std();
        push_exp(14, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 6'd7);
        start_run(-1, 7);
        wait_done();

        // Masked entry 1 would fail; entry 3 checks $zero == 0.
        set_std(); exp_en = 4'b1101;
        set_entry(1, 5'd12, 32'h7);
        set_entry(3, 5'd0, 32'h0);
        push_exp(21, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 6'd14);
        start_run(10, -1);
        wait_done();

        // $zero entry expecting 1 fails on the last entry.
        set_std(); exp_en = 4'b1101;
        set_entry(1, 5'd12, 32'h7);
        set_entry(3, 5'd0, 32'h1);
        push_exp(21, 1'b0, 1'b0, 3'd1, 2'd3, 32'h0, 6'd14);
        start_run(10, -1);
        wait_done();

        // Reset pulse mid-CHECK, then the first scenario again.
        set_std();
        start_run(10, -1);
        while (cyc < 18) step();
        chk("mid_state_check", 32'(dut.state), 32'(CHECK));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        chk("mid_state_run", 32'(dut.state), 32'(RUN));
        push_exp(21, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 6'd14);
        reset = 1'b0;
        cyc = 0;
        drive();
        wait_done();

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
